// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: one requester's req/ack port into the SRAM arbiter.
// master = requester (Req/WE/Addr/WData/BE out), slave = arbiter (RData/Ack out).
interface sram_arbiter_if;
  logic        Req;
  logic        WE;
  logic [19:0] Addr;
  logic [15:0] WData;
  logic [1:0]  BE;
  logic [15:0] RData;
  logic        Ack;

  modport master (
    output Req, WE, Addr, WData, BE,
    input  RData, Ack
  );

  modport slave (
    input  Req, WE, Addr, WData, BE,
    output RData, Ack
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter/sequencer for an async 16-bit SRAM.
// Ports: Clk, Reset (sync, active-high); R0/R1 requester interfaces
// (slave modport); SRAM_CE/OE/WE/LB/UB (active low), SRAM_ADDR, SRAM_DQ.
// Cycle: IDLE -> SETUP -> ACCESS x(WaitStates+1) -> DONE (Ack pulse).
// `define SRAM_ARB_ROUND_ROBIN_EN for round-robin ties (else R0 > R1).
module sram_arbiter #(
  parameter int unsigned WaitStates = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  sram_arbiter_if.slave R0,
  sram_arbiter_if.slave R1,
  output logic          SRAM_CE,
  output logic          SRAM_OE,
  output logic          SRAM_WE,
  output logic          SRAM_LB,
  output logic          SRAM_UB,
  output logic [19:0]   SRAM_ADDR,
  inout  wire  [15:0]   SRAM_DQ
);

  localparam logic [3:0] WS = 4'(WaitStates);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;

  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        wen_q, wen_d;
  logic        lb_q, lb_d;
  logic        ub_q, ub_d;
  logic [19:0] sa_q, sa_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] rd0_q, rd0_d;
  logic [15:0] rd1_q, rd1_d;

  logic        pick;
  logic        busy;
  logic        acc;
  logic        cap;
  logic [15:0] capt;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a tie the requester not served last wins.
  assign pick = (R0.Req && R1.Req) ? ~last_q : ~R0.Req;

  always_ff @(posedge Clk) begin
    if (Reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign pick = ~R0.Req;
`endif

  // Disabled byte lanes read back as zero.
  assign capt = {be_q[1] ? SRAM_DQ[15:8] : 8'h00,
                 be_q[0] ? SRAM_DQ[7:0]  : 8'h00};
  assign cap  = (state_q == ACCESS) && (cnt_q == 4'd0) && !we_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (R0.Req || R1.Req) begin
          state_d = SETUP;
          gnt_d   = pick;
          we_d    = pick ? R1.WE    : R0.WE;
          addr_d  = pick ? R1.Addr  : R0.Addr;
          wdata_d = pick ? R1.WData : R0.WData;
          be_d    = pick ? R1.BE    : R0.BE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          last_d  = pick;
`endif
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they register in
  // step with the state they belong to.
  always_comb begin
    busy     = (state_d == SETUP) || (state_d == ACCESS);
    acc      = (state_d == ACCESS);
    ce_d     = ~busy;
    oe_d     = ~(acc & ~we_d);
    wen_d    = ~(acc & we_d);
    lb_d     = ~(busy & be_d[0]);
    ub_d     = ~(busy & be_d[1]);
    sa_d     = (state_d == SETUP) ? addr_d : sa_q;
    dq_oe_d  = acc & we_d;
    dq_out_d = wdata_d;
    ack0_d   = (state_d == DONE) & ~gnt_d;
    ack1_d   = (state_d == DONE) & gnt_d;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    if (cap) begin
      if (gnt_q) rd1_d = capt;
      else       rd0_d = capt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      wen_q    <= 1'b1;
      lb_q     <= 1'b1;
      ub_q     <= 1'b1;
      sa_q     <= '0;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      wen_q    <= wen_d;
      lb_q     <= lb_d;
      ub_q     <= ub_d;
      sa_q     <= sa_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  assign SRAM_CE   = ce_q;
  assign SRAM_OE   = oe_q;
  assign SRAM_WE   = wen_q;
  assign SRAM_LB   = lb_q;
  assign SRAM_UB   = ub_q;
  assign SRAM_ADDR = sa_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;

  assign R0.Ack   = ack0_q;
  assign R1.Ack   = ack1_q;
  assign R0.RData = rd0_q;
  assign R1.RData = rd1_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-port arbiter and sequencer for the board's asynchronous 16-bit SRAM. It shares the single SRAM between requester 0 (CPU memory interface) and requester 1 (loader/DMA). It converts each requester's req/ack transaction into a timed SRAM cycle on the active-low CE/OE/WE/LB/UB strobes and the bidirectional DQ bus. It sits between the CPU datapath and the SRAM pins (or the simulation memory model).

Parameters:
WaitStates, 1, extra ACCESS cycles beyond the first (legal 0..15; 4-bit counter)

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
R0_Req  input  1  requester 0 access request; held with R0_* operands until R0_Ack
R0_WE  input  1  1 = write, 0 = read
R0_Addr  input  20  word address
R0_WData  input  16  write data
R0_BE  input  2  byte enables; [1] upper byte, [0] lower byte
R0_RData  output  16  read data; valid in the R0_Ack cycle and held until the next R0 read completes
R0_Ack  output  1  one-cycle completion pulse
R1_Req, R1_WE, R1_Addr, R1_WData, R1_BE, R1_RData, R1_Ack  (same as R0_*)  requester 1
SRAM_CE  output  1  chip enable, active low
SRAM_OE  output  1  output enable, active low
SRAM_WE  output  1  write enable, active low
SRAM_LB  output  1  lower-byte select, active low
SRAM_UB  output  1  upper-byte select, active low
SRAM_ADDR  output  20  SRAM address
SRAM_DQ  inout  16  SRAM data bus

Behaviour:
- All outputs are registered, except SRAM_DQ, which is driven from registered data and a registered enable.
- Reset values: CE=OE=WE=LB=UB=1, SRAM_ADDR=0, DQ=Z, R0_Ack=R1_Ack=0, R0_RData=R1_RData=0, state IDLE, grant=0.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Sample Req lines.
  - If any is high, latch the winner's Addr/WE/WData/BE and grant, then go to SETUP.
  - Default arbitration is fixed priority: R0 wins over R1.
- SETUP (1 cycle):
  - CE=0, ADDR=latched addr, LB=~BE[0], UB=~BE[1].
  - OE=1, WE=1, DQ=Z.
- ACCESS (WaitStates+1 cycles, down-counter):
  - Read: OE=0, WE=1, DQ=Z.
  - Write: WE=0, OE=1, DQ driven with latched WData.
  - On the last ACCESS cycle, a read captures SRAM_DQ into the granted RData register. Disabled byte lanes capture 0.
- DONE (1 cycle):
  - CE=OE=WE=LB=UB=1, DQ=Z.
  - Granted Ack=1; the other Ack stays 0.
  - Requests are not sampled in DONE.
- Latency: Req sampled in IDLE at cycle 0 -> Ack in cycle 3+WaitStates (WaitStates=1: 4 cycles). Minimum 4+WaitStates cycles between back-to-back grants.
- Handshake:
  - Requester drops Req in the cycle after Ack. Req still high at the next IDLE starts a new transaction.
  - Operand changes while Req is high and before Ack are ignored, because they were latched in IDLE.
  - Req dropped before Ack: the transaction still completes and Ack still pulses.
- DQ is never driven in SETUP, DONE, IDLE or during reads, so there is no bus contention with the SRAM.
- BE=2'b00: full cycle runs with LB=UB=1; no data changes; Ack pulses normally.
- Address is passed through unchanged; out-of-range handling belongs to the memory.
- Simultaneous R0_Req and R1_Req in IDLE: one grant per the arbitration rule; the loser waits, holding Req.
- Reset mid-operation: the next edge forces all reset values. The in-flight access is abandoned without Ack and no strobe glitch is held low.

Optional Feature:
SRAM_ARB_ROUND_ROBIN_EN
- Defined: round-robin arbitration.
  - A one-bit last-grant register records the last requester served.
  - On a tie, the requester not served last wins.
  - Reset sets last-grant=1, so R0 wins the first tie.
  - A lone requester is always granted.
- Undefined: fixed priority R0 > R1; the last-grant register is not built.

Test Plan:
- Reset, WaitStates=1, R0 write Addr=0x00005 WData=0xBEEF BE=11 -> SETUP CE=0/WE=1, then 2 cycles WE=0 with DQ=0xBEEF, R0_Ack in cycle 4, memory[5]=0xBEEF.
- R1 read Addr=0x00005 BE=01 after the above -> OE=0 for 2 cycles, DQ never driven, R1_RData=0x00EF at R1_Ack, R0_Ack stays 0.
- R0 and R1 both hold Req for 3 transactions each -> fixed priority: all three R0 grants before any R1. With SRAM_ARB_ROUND_ROBIN_EN: grants alternate R0,R1,R0,R1,R0,R1.
- Reset asserted during the 2nd ACCESS cycle of a write -> next edge CE=OE=WE=LB=UB=1, DQ=Z, no Ack, state IDLE; memory write is not completed.
- WaitStates=0, R0 write BE=10 WData=0x1234 to a word holding 0xAAAA -> Ack in cycle 3, word=0x12AA. Then BE=00 write -> Ack pulses, word unchanged.
- R0_Req dropped the cycle after SETUP entry -> transaction completes, single R0_Ack pulse, FSM returns to IDLE and issues no further grant.
